video_pattern_generator: RTL and testbench
==========================================

// Module: video_pattern_generator
// PURPOSE
//  Parametrised AXI4-Stream video test-pattern source: one beat per pixel, tuser on first pixel of frame,
//  tlast on last pixel of line. Adds full valid/ready compliance (data held on stall), selectable
//  patterns, optional line/frame blanking and enable/stop control. Feeds video sinks/DMA under test.
// PARAMETERS
//  IMG_WIDTH   640  active pixels per line (>=8, multiple of 8)
//  IMG_HEIGHT  480  active lines per frame (>=2)
//  COMP_W      8    bits per colour component; TDATA_W = 4*COMP_W (derived localparam)
//  H_BLANK     0    idle cycles (tvalid=0) after each line's tlast beat, except last line
//  V_BLANK     0    idle cycles (tvalid=0) after the frame's final beat
//  CHK_LOG2    5    checkerboard square size = 2**CHK_LOG2 pixels
//  CNT_W       12   width of x/y/blank counters; must hold max(IMG_WIDTH,IMG_HEIGHT,H_BLANK,V_BLANK)
// PORTS
//  clk_i          in   1        clock
//  rst_ni         in   1        asynchronous reset, active low
//  enable_i       in   1        1 = run continuously; 0 = stop after current frame completes
//  mode_i         in   2        pattern select, sampled at frame start only
//  m_axis_tready  in   1        downstream ready
//  m_axis_tvalid  out  1        beat valid
//  m_axis_tdata   out  TDATA_W  {COMP_W'0, R, G, B}, B in LSBs
//  m_axis_tlast   out  1        last pixel of line
//  m_axis_tuser   out  1        first pixel of frame (x=0,y=0)
//  frame_done_o   out  1        1-cycle pulse when final beat of frame is accepted
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, x=y=0, all outputs 0.
//  All outputs registered. Beat accepted = tvalid & tready; x/y advance only on acceptance.
//  While tvalid & ~tready: tdata/tlast/tuser held stable, tvalid stays 1 (never withdrawn).
//  FSM: IDLE -> ACTIVE when enable_i=1; tvalid=1 with pixel (0,0), tuser=1 on the next cycle.
//   ACTIVE: on acceptance x++; x==IMG_WIDTH-1 beat carries tlast=1, then x=0, y++.
//   after tlast beat, y<IMG_HEIGHT-1: H_BLANK>0 -> HBLANK (count H_BLANK cycles, tvalid=0) -> ACTIVE;
//     H_BLANK=0 -> next line's first beat offered the following cycle (back-to-back).
//   final beat (x=W-1,y=H-1) accepted: frame_done_o=1 that cycle+1, y=0; V_BLANK>0 -> VBLANK
//     (V_BLANK cycles) then frame start; enable_i=0 at that point -> IDLE instead.
//  enable_i deassert mid-frame: frame finishes normally, then IDLE. No partial frames ever emitted.
//  mode_i latched into mode_q at each frame start; changes mid-frame ignored.
//  Patterns (x,y = current pixel; MAX = 2**COMP_W-1):
//   0 gradient: R=G=B = ((x+y)>>1) truncated to COMP_W bits (x+y computed at CNT_W+1 bits)
//   1 colour bars: 8 bars of IMG_WIDTH/8 px via bar counter (no divider): white,yellow,cyan,green,
//     magenta,red,blue,black (components MAX or 0)
//   2 checker: x[CHK_LOG2]^y[CHK_LOG2] ? R=G=B=MAX : 0
//   3 ramp: R=x[COMP_W-1:0], G=y[COMP_W-1:0], B=0
//  Reset mid-frame: stream aborts immediately; after release next frame restarts at (0,0) with tuser.
// CONFIGURATION
//  PATGEN_FRAME_CNT_EN defined: adds output frame_cnt_o [15:0] (reset 0, increments on frame_done_o,
//   wraps 0xFFFF->0); gradient (mode 0) becomes ((x+y)>>1)+frame_cnt_o[COMP_W-1:0] (animated, wraps).
//  Undefined: port absent, gradient static as above; no other difference.
// TESTING (bench params IMG_WIDTH=16, IMG_HEIGHT=4, H_BLANK=2, V_BLANK=3, CHK_LOG2=2, tready=1 unless stated)
//  Reset/start: rst_ni=0 -> all outputs 0; release, enable_i=1 -> first beat tuser=1, x=0, tdata=0.
//  Gradient: mode 0, pixel (x=3,y=5 with IMG_HEIGHT=8) -> tdata=0x00040404; tlast only on x=15 beats.
//  Backpressure: drop tready for 5 cycles mid-line -> tvalid=1, tdata unchanged; no pixel skipped/duplicated.
//  Blanking/framing: count 16 beats, 2 idle cycles between lines, 3 after frame; frame_done_o one pulse/frame.
//  Modes: mode 1 x=2 -> 0x00FFFF00 (yellow), x=15 -> 0; mode 2 (4,0) -> 0x00FFFFFF; mode_i change mid-frame
//   takes effect only at next tuser beat.
//  Stop/reset: enable_i=0 at y=1 -> frame completes, then tvalid stays 0; rst_ni pulse mid-line -> restart at (0,0).

Source files
------------

// File: rtl/video_pattern_generator.sv
// AXI4-Stream video test-pattern source: gradient, colour bars, checker and ramp with line/frame blanking.
// Define PATGEN_FRAME_CNT_EN to add frame_cnt_o and animate the gradient pattern per frame.
module video_pattern_generator #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int COMP_W     = 8,
   parameter int H_BLANK    = 0,
   parameter int V_BLANK    = 0,
   parameter int CHK_LOG2   = 5,
   parameter int CNT_W      = 12
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  enable_i,
   input  logic [1:0]            mode_i,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tvalid,
   output logic [4*COMP_W-1:0]   m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  frame_done_o
`ifdef PATGEN_FRAME_CNT_EN
   ,
   output logic [15:0]           frame_cnt_o
`endif
);
   localparam int TDATA_W = 4*COMP_W;
   localparam logic [CNT_W-1:0] W_LAST   = CNT_W'(IMG_WIDTH - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(IMG_HEIGHT - 1);
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(IMG_WIDTH/8 - 1);
   localparam logic [CNT_W-1:0] HB_LAST  = CNT_W'(H_BLANK - 1);
   localparam logic [CNT_W-1:0] VB_LAST  = CNT_W'(V_BLANK - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   x_reg, x_next, y_reg, y_next;
   logic [CNT_W-1:0]   blank_reg, blank_next;
   logic [CNT_W-1:0]   bar_px_reg, bar_px_next;
   logic [2:0]         bar_idx_reg, bar_idx_next;
   logic [1:0]         mode_reg, mode_next;
   logic               tvalid_reg, valid_next;
   logic [TDATA_W-1:0] tdata_reg;
   logic               tlast_reg, tuser_reg, done_reg, done_next;
   logic               accept, start_frame;
   logic [CNT_W:0]     coord_sum;
   logic [COMP_W-1:0]  grad_val, r_val, g_val, b_val;
`ifdef PATGEN_FRAME_CNT_EN
   logic [15:0]        fcnt_reg, fcnt_next;
`endif

   assign accept = tvalid_reg & m_axis_tready;

   always_comb begin
      state_next   = state_reg;
      x_next       = x_reg;
      y_next       = y_reg;
      blank_next   = blank_reg;
      bar_px_next  = bar_px_reg;
      bar_idx_next = bar_idx_reg;
      mode_next    = mode_reg;
      valid_next   = tvalid_reg;
      done_next    = 1'b0;
      start_frame  = 1'b0;
      case (state_reg)
         IDLE: begin
            valid_next = 1'b0;
            if (enable_i) start_frame = 1'b1;
         end
         ACTIVE: begin
            if (accept) begin
               if (x_reg == W_LAST) begin
                  x_next       = '0;
                  bar_px_next  = '0;
                  bar_idx_next = '0;
                  if (y_reg == H_LAST) begin
                     y_next    = '0;
                     done_next = 1'b1;
                     if (V_BLANK > 0) begin
                        state_next = VBLANK;
                        blank_next = '0;
                        valid_next = 1'b0;
                     end else if (enable_i) begin
                        start_frame = 1'b1;
                     end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                     end
                  end else begin
                     y_next = y_reg + 1'b1;
                     if (H_BLANK > 0) begin
                        state_next = HBLANK;
                        blank_next = '0;
                        valid_next = 1'b0;
                     end
                  end
               end else begin
                  x_next = x_reg + 1'b1;
                  // Bar index tracks x without a divider
                  if (bar_px_reg == BAR_LAST) begin
                     bar_px_next  = '0;
                     bar_idx_next = bar_idx_reg + 3'd1;
                  end else begin
                     bar_px_next = bar_px_reg + 1'b1;
                  end
               end
            end
         end
         HBLANK: begin
            if (blank_reg == HB_LAST) begin
               state_next = ACTIVE;
               valid_next = 1'b1;
            end else begin
               blank_next = blank_reg + 1'b1;
            end
         end
         VBLANK: begin
            if (blank_reg == VB_LAST) begin
               if (enable_i) begin
                  start_frame = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               blank_next = blank_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (start_frame) begin
         state_next   = ACTIVE;
         x_next       = '0;
         y_next       = '0;
         bar_px_next  = '0;
         bar_idx_next = '0;
         mode_next    = mode_i;
         valid_next   = 1'b1;
      end
   end

`ifdef PATGEN_FRAME_CNT_EN
   assign fcnt_next   = done_next ? fcnt_reg + 16'd1 : fcnt_reg;
   assign frame_cnt_o = fcnt_reg;
`endif

   // Pixel is built from the next coordinates so the output register holds it through stalls
   always_comb begin
      coord_sum = {1'b0, x_next} + {1'b0, y_next};
      grad_val  = COMP_W'(coord_sum >> 1);
`ifdef PATGEN_FRAME_CNT_EN
      grad_val  = grad_val + COMP_W'(fcnt_next);
`endif
      r_val = '0;
      g_val = '0;
      b_val = '0;
      case (mode_next)
         2'd0: begin
            r_val = grad_val;
            g_val = grad_val;
            b_val = grad_val;
         end
         2'd1: begin
            r_val = {COMP_W{~bar_idx_next[1]}};
            g_val = {COMP_W{~bar_idx_next[2]}};
            b_val = {COMP_W{~bar_idx_next[0]}};
         end
         2'd2: begin
            r_val = {COMP_W{x_next[CHK_LOG2] ^ y_next[CHK_LOG2]}};
            g_val = r_val;
            b_val = r_val;
         end
         default: begin
            r_val = COMP_W'(x_next);
            g_val = COMP_W'(y_next);
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg   <= IDLE;
         x_reg       <= '0;
         y_reg       <= '0;
         blank_reg   <= '0;
         bar_px_reg  <= '0;
         bar_idx_reg <= '0;
         mode_reg    <= '0;
         tvalid_reg  <= 1'b0;
         tdata_reg   <= '0;
         tlast_reg   <= 1'b0;
         tuser_reg   <= 1'b0;
         done_reg    <= 1'b0;
`ifdef PATGEN_FRAME_CNT_EN
         fcnt_reg    <= '0;
`endif
      end else begin
         state_reg   <= state_next;
         x_reg       <= x_next;
         y_reg       <= y_next;
         blank_reg   <= blank_next;
         bar_px_reg  <= bar_px_next;
         bar_idx_reg <= bar_idx_next;
         mode_reg    <= mode_next;
         tvalid_reg  <= valid_next;
         tdata_reg   <= valid_next ? {{COMP_W{1'b0}}, r_val, g_val, b_val} : '0;
         tlast_reg   <= valid_next && (x_next == W_LAST);
         tuser_reg   <= valid_next && (x_next == '0) && (y_next == '0);
         done_reg    <= done_next;
`ifdef PATGEN_FRAME_CNT_EN
         fcnt_reg    <= fcnt_next;
`endif
      end
   end

   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tlast  = tlast_reg;
   assign m_axis_tuser  = tuser_reg;
   assign frame_done_o  = done_reg;
endmodule

// File: tb/tb_video_pattern_generator.sv
// Self-checking bench for video_pattern_generator: per-cycle scoreboard of pixel order, blanking and framing.
module tb_video_pattern_generator;
   localparam int W = 16, H = 4, HB = 2, VB = 3, CHK = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        enable_i = 1'b0;
   logic [1:0]  mode_i = 2'd0;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, frame_done_o;
   logic [31:0] m_axis_tdata;
`ifdef PATGEN_FRAME_CNT_EN
   logic [15:0] frame_cnt_o;
`endif

   video_pattern_generator #(
      .IMG_WIDTH(W), .IMG_HEIGHT(H), .COMP_W(8), .H_BLANK(HB),
      .V_BLANK(VB), .CHK_LOG2(CHK), .CNT_W(12)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i),
      .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .frame_done_o(frame_done_o)
`ifdef PATGEN_FRAME_CNT_EN
      , .frame_cnt_o(frame_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference pixel straight from the pattern definitions
   function automatic logic [31:0] model_pixel(input int mode, input int x, input int y, input int fcnt);
      logic [7:0]  c;
      logic [23:0] rgb;
      int          bar;
      rgb = 24'h0;
      case (mode)
         0: begin
            c   = 8'(((x + y) / 2 + fcnt) % 256);
            rgb = {c, c, c};
         end
         1: begin
            bar = x / (W / 8);
            case (bar)
               0: rgb = 24'hFFFFFF;
               1: rgb = 24'hFFFF00;
               2: rgb = 24'h00FFFF;
               3: rgb = 24'h00FF00;
               4: rgb = 24'hFF00FF;
               5: rgb = 24'hFF0000;
               6: rgb = 24'h0000FF;
               default: rgb = 24'h000000;
            endcase
         end
         2: rgb = ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
         default: rgb = {8'(x), 8'(y), 8'h00};
      endcase
      return {8'h00, rgb};
   endfunction

   // Scoreboard state: expected coordinate of the beat on the bus and the gap kind preceding it
   int         ex = 0, ey = 0, kind = 3, gap = 0, frame_mode = 0, m_fcnt = 0, nframes = 0;
   bit         gap_en_ok = 1'b1, prev_stall = 1'b0, prev_final = 1'b0;
   logic [1:0] mode_prev = 2'd0;

   always @(negedge clk_i) begin
      logic [31:0] exp_px;
      int          fc;
      if (!rst_ni) begin
         check("rst_tvalid", 32'(m_axis_tvalid), 0);
         check("rst_tdata", m_axis_tdata, 0);
         check("rst_tlast", 32'(m_axis_tlast), 0);
         check("rst_tuser", 32'(m_axis_tuser), 0);
         check("rst_frame_done", 32'(frame_done_o), 0);
         ex = 0; ey = 0; kind = 3; gap = 0; gap_en_ok = 1'b1;
         prev_stall = 1'b0; prev_final = 1'b0; m_fcnt = 0;
      end else begin
         check("frame_done", 32'(frame_done_o), 32'(prev_final));
`ifdef PATGEN_FRAME_CNT_EN
         check("frame_cnt", 32'(frame_cnt_o), 32'(m_fcnt & 16'hFFFF));
         fc = m_fcnt;
`else
         fc = 0;
`endif
         if (m_axis_tvalid) begin
            if (!prev_stall) begin
               case (kind)
                  0: check("midline_gap", gap, 0);
                  1: check("hblank_gap", gap, HB);
                  2: if (gap_en_ok) check("vblank_gap", gap, VB);
                     else check("vblank_min_gap", 32'(gap >= VB), 1);
                  default: ;
               endcase
               if (ex == 0 && ey == 0) frame_mode = int'(mode_prev);
            end
            exp_px = model_pixel(frame_mode, ex, ey, fc);
            check("tdata", m_axis_tdata, exp_px);
            check("tlast", 32'(m_axis_tlast), 32'(ex == W - 1));
            check("tuser", 32'(m_axis_tuser), 32'(ex == 0 && ey == 0));
            if (frame_mode == 1 && ex == 2) check("bar_yellow", m_axis_tdata, 32'h00FFFF00);
            if (frame_mode == 1 && ex == 15) check("bar_black", m_axis_tdata, 32'h00000000);
            if (frame_mode == 2 && ex == 4 && ey == 0) check("checker_4_0", m_axis_tdata, 32'h00FFFFFF);
`ifndef PATGEN_FRAME_CNT_EN
            if (frame_mode == 0 && ex == 3 && ey == 1) check("grad_3_1", m_axis_tdata, 32'h00020202);
`endif
            prev_final = 1'b0;
            if (m_axis_tready) begin
               if (ex == W - 1) begin
                  ex = 0;
                  if (ey == H - 1) begin
                     ey = 0; kind = 2; prev_final = 1'b1; m_fcnt++; nframes++;
                     $display("frame %0d mode %0d complete at %0t", nframes, frame_mode, $time);
                  end else begin
                     ey++; kind = 1;
                  end
               end else begin
                  ex++; kind = 0;
               end
               gap = 0;
               gap_en_ok = 1'b1;
            end
            prev_stall = !m_axis_tready;
         end else begin
            if (prev_stall) check("stall_tvalid_held", 32'(m_axis_tvalid), 1);
            gap++;
            if (!enable_i) gap_en_ok = 1'b0;
            prev_stall = 1'b0;
            prev_final = 1'b0;
         end
      end
      mode_prev = mode_i;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (!frame_done_o && n < budget) begin
         tick();
         n++;
      end
      check(name, 32'(frame_done_o), 1);
      tick();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] held;
      int          n;
      check("model_grad_3_5", model_pixel(0, 3, 5, 0), 32'h00040404);
      check("model_bar_2", model_pixel(1, 2, 0, 0), 32'h00FFFF00);
      check("model_checker_4_0", model_pixel(2, 4, 0, 0), 32'h00FFFFFF);

      repeat (3) tick();
      check("reset_tvalid", 32'(m_axis_tvalid), 0);
      rst_ni = 1'b1;
      tick();
      check("idle_tvalid", 32'(m_axis_tvalid), 0);
      enable_i = 1'b1;
      n = 0;
      while (!m_axis_tvalid && n < 10) begin tick(); n++; end
      check("start_tvalid", 32'(m_axis_tvalid), 1);
      check("start_tuser", 32'(m_axis_tuser), 1);
      check("start_tdata", m_axis_tdata, 0);
      check("start_tlast", 32'(m_axis_tlast), 0);

      wait_done(200, "frame0_done");
      wait_done(200, "frame1_done");

      // Backpressure in the middle of a line
      n = 0;
      while (!(m_axis_tvalid && ex == 7) && n < 100) begin tick(); n++; end
      held = m_axis_tdata;
      m_axis_tready = 1'b0;
      repeat (5) begin
         tick();
         check("stall_tvalid", 32'(m_axis_tvalid), 1);
         check("stall_tdata", m_axis_tdata, held);
      end
      m_axis_tready = 1'b1;

      // Each pattern, with a mid-frame mode change that must be ignored
      for (int m = 1; m < 4; m++) begin
         wait_done(300, "mode_frame_done");
         mode_i = 2'(m);
         repeat (30) tick();
         mode_i = 2'(m ^ 1);
      end
      wait_done(300, "mode_last_done");

      // Stop: deassert enable on line 1, frame must complete then stay idle
      n = 0;
      while (!(m_axis_tvalid && ey == 1) && n < 200) begin tick(); n++; end
      enable_i = 1'b0;
      wait_done(300, "stop_frame_done");
      repeat (20) begin
         tick();
         check("stopped_tvalid", 32'(m_axis_tvalid), 0);
      end
      enable_i = 1'b1;

      // Reset pulse mid-line
      n = 0;
      while (!(m_axis_tvalid && ex == 5 && ey == 2) && n < 300) begin tick(); n++; end
      rst_ni = 1'b0;
      tick();
      check("midrst_tvalid", 32'(m_axis_tvalid), 0);
      tick();
      rst_ni = 1'b1;
      n = 0;
      while (!m_axis_tvalid && n < 10) begin tick(); n++; end
      check("restart_tvalid", 32'(m_axis_tvalid), 1);
      check("restart_tuser", 32'(m_axis_tuser), 1);

      // Randomised backpressure, mode and enable activity
      for (int i = 0; i < 3000; i++) begin
         m_axis_tready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) mode_i = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 499) == 0) enable_i = ~enable_i;
         tick();
      end
      m_axis_tready = 1'b1;
      enable_i = 1'b1;
      wait_done(400, "final_frame_done");
      repeat (5) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
